clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 94 +++++++++
 tb/tb_clk_div_prog.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered divided clock plus start-of-period tick,
// with a pending-divisor handshake that swaps the divisor only at a period boundary.
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             wrap, apply, load_ok;

  always_comb begin
    wrap    = enable && (cnt_q == div_q - ONE);
    // A frozen divider has no boundary to wait for, so a pending value applies at once.
    apply   = busy_q && (wrap || !enable);
    load_ok = div_load && (div_val != '0);

    cnt_d  = cnt_q;
    div_d  = div_q;
    pend_d = pend_q;
    busy_d = busy_q;

    if (apply) begin
      div_d = pend_q;
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
    end

    // A load landing on the apply edge stays pending for the next boundary.
    if (load_ok) begin
      pend_d = div_val;
      busy_d = 1'b1;
    end else if (apply) begin
      busy_d = 1'b0;
    end

    clk_out_d = (cnt_d >= (div_d >> 1));
    tick_d    = wrap;
    ack_d     = apply;
    err_d     = div_load && (div_val == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= DEF_DIV;
      pend_q    <= '0;
      busy_q    <= 1'b0;
      clk_out_q <= (DEF_DIV == ONE);
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign div_ack = ack_q;
  assign div_err = err_q;
  assign busy    = busy_q;
  assign cur_div = div_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scenario bench for clk_div_prog: each task queues the expected output vector per
// cycle as it drives stimulus and checks it once the edge has produced the outputs.
module tb_clk_div_prog;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_val = '0;
  logic       div_ack, div_err, busy, clk_out, tick;
  logic [7:0] cur_div;

  int errors = 0;
  int checks = 0;
  logic [12:0] sb[$];

  clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .busy     (busy),
    .cur_div  (cur_div),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clock = ~clock;

  // Vector layout: {clk_out, tick, busy, div_ack, div_err, cur_div[7:0]}
  function automatic logic [12:0] pk(input bit c, input bit t, input bit b,
                                     input bit a, input bit e, input int d);
    return {c, t, b, a, e, 8'(d)};
  endfunction

  function automatic logic [12:0] obs();
    return {clk_out, tick, busy, div_ack, div_err, cur_div};
  endfunction

  task automatic cycle(input bit rst, input bit en, input bit ld, input int val);
    @(negedge clock);
    reset    = rst;
    enable   = en;
    div_load = ld;
    div_val  = 8'(val);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] got, e;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(pk(0, 0, 0, 0, 0, 2));
      cycle(1, 1, 1, 5);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_default_div2();
    logic [12:0] got, e;
    for (int k = 1; k <= 20; k++) begin
      sb.push_back(pk((k % 2) == 1, (k % 2) == 0, 0, 0, 0, 2));
      cycle(0, 1, 0, 0);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL div2[%0d] got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_load5();
    logic [12:0] got, e;
    int acks = 0;
    for (int k = 0; k <= 16; k++) begin
      int c;
      c = (k - 1) % 5;
      if (k == 0)      sb.push_back(pk(1, 0, 1, 0, 0, 2));
      else if (k == 1) sb.push_back(pk(0, 1, 0, 1, 0, 5));
      else             sb.push_back(pk(c >= 2, c == 0, 0, 0, 0, 5));
      cycle(0, 1, k == 0, 5);
      if (div_ack === 1'b1) acks++;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL load5[%0d] got=%b exp=%b", k, got, e);
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL load5_ack_count got=%0d exp=1", acks);
    end
  endtask

  task automatic test_last_wins();
    logic [12:0] got, e;
    for (int k = 0; k <= 10; k++) begin
      int c;
      c = (k - 4) % 3;
      if (k == 0)      sb.push_back(pk(0, 0, 1, 0, 0, 5));
      else if (k <= 3) sb.push_back(pk(1, 0, 1, 0, 0, 5));
      else if (k == 4) sb.push_back(pk(0, 1, 0, 1, 0, 3));
      else             sb.push_back(pk(c >= 1, c == 0, 0, 0, 0, 3));
      cycle(0, 1, k <= 1, (k == 0) ? 6 : 3);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL last_wins[%0d] got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_zero_load();
    logic [12:0] got, e;
    for (int k = 0; k <= 5; k++) begin
      int c;
      c = (k + 1) % 3;
      sb.push_back(pk(c >= 1, c == 0, 0, 0, k == 0, 3));
      cycle(0, 1, k == 0, 0);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL zero_load[%0d] got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_freeze();
    logic [12:0] got, e;
    for (int k = 0; k <= 13; k++) begin
      int c;
      bit en;
      c  = (k - 9) % 4;
      en = (k == 0) || (k >= 10);
      if (k <= 7)      sb.push_back(pk(1, 0, 0, 0, 0, 3));
      else if (k == 8) sb.push_back(pk(1, 0, 1, 0, 0, 3));
      else if (k == 9) sb.push_back(pk(0, 0, 0, 1, 0, 4));
      else             sb.push_back(pk(c >= 2, c == 0, 0, 0, 0, 4));
      cycle(0, en, k == 8, 4);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL freeze[%0d] got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_reset_busy();
    logic [12:0] got, e;
    for (int k = 0; k <= 17; k++) begin
      int j;
      j = k - 5;
      case (k)
        0:       sb.push_back(pk(0, 0, 1, 0, 0, 4));
        1, 2:    sb.push_back(pk(1, 0, 1, 0, 0, 4));
        3:       sb.push_back(pk(0, 1, 1, 1, 0, 7));
        4:       sb.push_back(pk(0, 0, 1, 0, 0, 7));
        5:       sb.push_back(pk(0, 0, 0, 0, 0, 2));
        default: sb.push_back(pk((j % 2) == 1, (j % 2) == 0, 0, 0, 0, 2));
      endcase
      cycle(k == 5, 1, (k == 0) || (k == 3), (k == 0) ? 7 : 9);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_busy[%0d] got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_div1();
    logic [12:0] got, e;
    for (int k = 0; k <= 4; k++) begin
      if (k == 0)      sb.push_back(pk(1, 0, 1, 0, 0, 2));
      else if (k == 1) sb.push_back(pk(1, 1, 0, 1, 0, 1));
      else             sb.push_back(pk(1, 1, 0, 0, 0, 1));
      cycle(0, 1, k == 0, 1);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL div1[%0d] got=%b exp=%b", k, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_div2();
    test_load5();
    test_last_wins();
    test_zero_load();
    test_freeze();
    test_reset_busy();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
